sr_fetch_buffer: RTL and testbench
==================================

Name: sr_fetch_buffer

Overview:
Instruction fetch front-end that sits directly upstream of the CPU decode stage.
- Issues in-order word fetch requests to an instruction memory with variable read latency (≥1 cycle).
- Buffers returned instructions, tagged with their PC, in a small FIFO.
- Presents them to decode through a valid/ready handshake.
- Handles branch redirects from execute by flushing the buffer and discarding responses still in flight.

Parameters:
DEPTH, 4, FIFO entries and maximum requests in flight; power of two, 2..16
RESET_PC, 32'h0000_0000, byte address fetched first after reset

Ports:
clk  in  1  clock
rst_n  in  1  reset; one clock, asynchronous, active-low
redirect  in  1  execute-stage branch taken; flush and restart at redirect_pc
redirect_pc  in  32  new byte PC; bits [1:0] ignored (treated as 0)
imReq  out  1  fetch request valid; memory accepts every asserted request
imAddr  out  32  word address of request = fetchPc >> 2
imAck  in  1  response valid; responses return in request order
imData  in  32  instruction word for the oldest outstanding request
instr_vld  out  1  FIFO head valid
instr  out  32  FIFO head instruction
instr_pc  out  32  FIFO head byte PC
instr_rdy  in  1  decode accepts head this cycle

Behaviour:
- Internal state:
  - fetchPc: next request PC.
  - respPc: PC of the next kept response.
  - count: FIFO occupancy, 0..DEPTH.
  - inflight: requests issued but not yet acked, 0..DEPTH.
  - drop: responses still to discard, 0..DEPTH.
  - FIFO of {pc, instr}.
- Reset (async, rst_n=0):
  - fetchPc=respPc=RESET_PC; count=inflight=drop=0.
  - imReq=0, instr_vld=0, instr=0, instr_pc=0.
  - imAck is ignored while in reset. The memory shares rst_n and abandons its requests.
- Request rule (combinational from registers):
  - imReq = ~redirect & (count + inflight - drop < DEPTH) & (inflight < DEPTH).
  - The first condition is a credit scheme: every non-dropped request has a reserved FIFO slot, so the FIFO never overflows.
  - On an issued request: fetchPc += 4 (32-bit wrap, no error), inflight += 1.
- Response rule, when imAck=1:
  - inflight -= 1.
  - If drop > 0: drop -= 1 and imData is discarded.
  - Otherwise: push {respPc, imData} and respPc += 4.
  - An imAck with inflight==0 is a protocol error; it is ignored and inflight does not underflow.
- Pop rule:
  - instr_vld = (count != 0).
  - When instr_vld & instr_rdy: pop the head.
  - Head outputs are registered; the new head is visible the next cycle.
  - Push and pop in the same cycle leave count unchanged and are legal at any occupancy.
- No bypass: an instruction acked at cycle T is presented at instr_vld in cycle T+1 at the earliest.
  - Minimum request-to-decode latency is therefore 2 cycles when memory latency is 1.
- Redirect, when redirect=1 in cycle T (highest priority):
  - FIFO flushed: count=0, and instr_vld=0 from T+1.
  - A pop in cycle T is still considered consumed by decode.
  - fetchPc = respPc = {redirect_pc[31:2], 2'b00}.
  - No request is issued in T.
  - drop = (inflight - drop) + drop, minus 1 if imAck in T. That is, every request outstanding after T's response is discarded; the response in T is itself discarded and never pushed.
  - First new request is issued at T+1; its instruction reaches instr_vld no earlier than T+3 with 1-cycle memory.
- Back-to-back redirects: each one restarts the sequence; drop accumulates correctly across them.
- Throughput: with 1-cycle memory and instr_rdy held at 1, one instruction per cycle in steady state.
- Full: with count==DEPTH, or credits exhausted, imReq=0 until a pop or a drop frees a credit.

Test Plan:
- Reset release, 1-cycle memory, instr_rdy=1, RESET_PC=0 → imAddr 0,1,2,… on consecutive cycles; instr_pc 0x0,0x4,0x8 on consecutive cycles from cycle 2; instr_vld never drops.
- instr_rdy=0 for 10 cycles, DEPTH=4 → exactly 4 requests issued and count=4; imReq stays 0; on instr_rdy=1 the entries are popped in PC order 0x0..0xC before any new PC appears.
- 3-cycle memory latency with redirect to 0x100 while 2 requests are in flight → both stale responses discarded; next instr_pc=0x100 with the matching imData; no stale PC ever appears at instr_vld.
- redirect coinciding with imAck and with a pop, then a second redirect to 0x200 one cycle later → only PC 0x200 and later are delivered; drop returns to 0; inflight never underflows.
- redirect_pc=0x103 → fetch restarts at imAddr 0x40; instr_pc=0x100.
- rst_n pulsed low mid-stream with FIFO half full → asynchronously instr_vld=0 and imReq=0; after release, fetch resumes at RESET_PC.

Source files
------------

// File: rtl/sr_fetch_buffer_if.sv
// Fetch-buffer bundle: instruction-memory request/response, decode-side
// valid/ready handshake and the execute-stage redirect.
// The master side is the fetch buffer, the slave side is its surroundings.
interface sr_fetch_buffer_if;
  // Redirect from execute
  logic        redirect;
  logic [31:0] redirect_pc;
  // Instruction memory
  logic        imReq;
  logic [31:0] imAddr;
  logic        imAck;
  logic [31:0] imData;
  // Decode handshake
  logic        instr_vld;
  logic [31:0] instr;
  logic [31:0] instr_pc;
  logic        instr_rdy;

  modport master (
    input  redirect, redirect_pc, imAck, imData, instr_rdy,
    output imReq, imAddr, instr_vld, instr, instr_pc
  );

  modport slave (
    output redirect, redirect_pc, imAck, imData, instr_rdy,
    input  imReq, imAddr, instr_vld, instr, instr_pc
  );
endinterface

// File: rtl/sr_fetch_buffer.sv
// Instruction fetch front-end. Issues in-order word fetches, buffers the
// returned words tagged with their PC in a DEPTH-entry FIFO and hands them to
// decode. A redirect flushes the FIFO and turns every outstanding request into
// a response to be discarded, so no stale instruction ever reaches decode.
module sr_fetch_buffer #(
  parameter int unsigned DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic              clk,
  input  logic              rst_n,
  sr_fetch_buffer_if.master bus
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = AW + 1;
  localparam logic [CW:0]   DEPTH_SUM = (CW + 1)'(DEPTH);
  localparam logic [CW-1:0] DEPTH_CNT = CW'(DEPTH);

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] word;
  } entry_t;

  entry_t        store [DEPTH];
  logic [AW-1:0] rd_ptr;
  logic [AW-1:0] wr_ptr;
  logic [CW-1:0] count;     // FIFO occupancy
  logic [CW-1:0] inflight;  // requests issued, not yet acked
  logic [CW-1:0] drop;      // outstanding responses to discard
  logic [31:0]   fetch_pc;  // PC of the next request
  logic [31:0]   resp_pc;   // PC of the next kept response

  logic [CW:0]   committed;
  logic          req;
  logic          ack_ok;
  logic          keep;
  logic          pop;
  logic [31:0]   target_pc;
  logic          unused_pc_bits;

  // Low address bits of the redirect target carry no information.
  assign target_pc      = {bus.redirect_pc[31:2], 2'b00};
  assign unused_pc_bits = ^bus.redirect_pc[1:0];

  // Credit check: every request that will be kept owns a FIFO slot, so a
  // response can always be pushed without back-pressure on the memory.
  assign committed = {1'b0, count} + {1'b0, inflight} - {1'b0, drop};

  // NOTE: imReq is gated with rst_n because the counters sit at zero during
  // reset, which would otherwise advertise a request while the memory is
  // itself being reset.
  assign req = rst_n & ~bus.redirect & (committed < DEPTH_SUM) & (inflight < DEPTH_CNT);

  // An ack with nothing outstanding is a protocol error and is ignored.
  assign ack_ok = bus.imAck & (inflight != '0);
  assign keep   = ack_ok & (drop == '0) & ~bus.redirect;
  assign pop    = (count != '0) & bus.instr_rdy;

  // Memory request outputs.
  assign bus.imReq  = req;
  assign bus.imAddr = {2'b00, fetch_pc[31:2]};

  // Head outputs come straight from flops; zero whenever the FIFO is empty.
  assign bus.instr_vld = (count != '0);
  assign bus.instr     = (count != '0) ? store[rd_ptr].word : 32'h0;
  assign bus.instr_pc  = (count != '0) ? store[rd_ptr].pc   : 32'h0;

  // Fetch/response PCs, pointers and the three occupancy counters.
  // NOTE: all state here uses non-blocking assignments so every update in
  // this block sees the pre-edge values of the others.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fetch_pc <= RESET_PC;
      resp_pc  <= RESET_PC;
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      count    <= '0;
      inflight <= '0;
      drop     <= '0;
    end else if (bus.redirect) begin
      // Everything still outstanding after this cycle's ack is stale, and
      // this cycle's ack (if any) is discarded as well.
      fetch_pc <= target_pc;
      resp_pc  <= target_pc;
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      count    <= '0;
      inflight <= inflight - CW'(ack_ok);
      drop     <= inflight - CW'(ack_ok);
    end else begin
      if (req) begin
        fetch_pc <= fetch_pc + 32'd4;
      end
      if (keep) begin
        resp_pc <= resp_pc + 32'd4;
        wr_ptr  <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      if (ack_ok && (drop != '0)) begin
        drop <= drop - 1'b1;
      end
      inflight <= inflight + CW'(req) - CW'(ack_ok);
      count    <= count + CW'(keep) - CW'(pop);
    end
  end

  // FIFO storage write.
  // NOTE: the storage array is deliberately not reset; the head outputs are
  // masked to zero while count is zero, so unwritten entries are never seen.
  always_ff @(posedge clk) begin
    if (keep) begin
      store[wr_ptr] <= '{pc: resp_pc, word: bus.imData};
    end
  end

endmodule

// File: tb/tb_sr_fetch_buffer.sv
// Self-checking bench for sr_fetch_buffer: a variable-latency in-order memory
// model, and a scoreboard that learns each expected {pc, instr} when a
// non-stale response is driven and compares it when decode pops the head.
module tb_sr_fetch_buffer;

  localparam int unsigned DEPTH    = 4;
  localparam logic [31:0] RESET_PC = 32'h0000_0000;

  typedef struct {
    logic [31:0] addr;
    int          tag;
    int          due;
  } mreq_t;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] word;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  sr_fetch_buffer_if bus ();

  sr_fetch_buffer #(.DEPTH(DEPTH), .RESET_PC(RESET_PC)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  mreq_t       mq[$];
  exp_t        sb[$];
  int          cyc = 0;
  int          epoch = 0;
  int          lat = 1;
  int          req_count = 0;
  logic [31:0] exp_addr = RESET_PC >> 2;
  int          ack_tag = 0;
  logic [31:0] ack_addr = '0;
  int          passed = 0;
  int          total = 0;

  function automatic logic [31:0] data_of(input logic [31:0] a);
    return (a * 32'h9E37_79B9) ^ 32'h1234_5678;
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) $display("FAIL %s: got %h expected %h", tag, got, exp);
    else passed++;
  endtask

  // Memory model plus monitor: drives acks just after the rising edge and
  // samples the whole bundle on the falling edge.
  initial begin : mem_monitor
    mreq_t r;
    exp_t  e;
    bus.imAck  = 1'b0;
    bus.imData = '0;
    forever begin
      @(posedge clk);
      cyc++;
      #1;
      if (!rst_n) begin
        bus.imAck = 1'b0;
        mq.delete();
      end else if (mq.size() != 0 && mq[0].due <= cyc) begin
        r          = mq.pop_front();
        bus.imAck  = 1'b1;
        bus.imData = data_of(r.addr);
        ack_tag    = r.tag;
        ack_addr   = r.addr;
      end else begin
        bus.imAck = 1'b0;
      end

      @(negedge clk);
      if (!rst_n) begin
        sb.delete();
        mq.delete();
        epoch++;
        exp_addr  = RESET_PC >> 2;
        req_count = 0;
      end else begin
        if (bus.instr_vld && bus.instr_rdy) begin
          if (sb.size() == 0) begin
            check("sb_underflow", 32'(sb.size()), 32'd1);
          end else begin
            e = sb.pop_front();
            check("pop_pc", bus.instr_pc, e.pc);
            check("pop_instr", bus.instr, e.word);
          end
        end
        if (bus.imAck && ack_tag == epoch && !bus.redirect)
          sb.push_back('{pc: ack_addr << 2, word: data_of(ack_addr)});
        if (bus.imReq) begin
          check("req_addr", bus.imAddr, exp_addr);
          exp_addr++;
          req_count++;
          mq.push_back('{addr: bus.imAddr, tag: epoch, due: cyc + lat});
        end
        if (bus.redirect) begin
          check("req_in_redirect", bus.imReq, 32'd0);
          sb.delete();
          epoch++;
          exp_addr = {2'b00, bus.redirect_pc[31:2]};
        end
      end
    end
  end

  task automatic do_reset();
    @(posedge clk);
    #2 rst_n = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #2 rst_n = 1'b1;
  endtask

  // Single-cycle redirect; returns just after it is deasserted.
  task automatic do_redirect(input logic [31:0] pc);
    @(posedge clk);
    #1 bus.redirect = 1'b1;
    bus.redirect_pc = pc;
    @(posedge clk);
    #1 bus.redirect = 1'b0;
  endtask

  task automatic wait_first(input string tag, input logic [31:0] pc, input int budget);
    bit found = 0;
    for (int k = 0; k < budget && !found; k++) begin
      @(negedge clk);
      if (bus.instr_vld) begin
        found = 1;
        check({tag, "_pc"}, bus.instr_pc, pc);
        check({tag, "_instr"}, bus.instr, data_of(pc >> 2));
      end
    end
    if (!found) check({tag, "_timeout"}, bus.instr_vld, 32'd1);
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin : stimulus
    bus.redirect    = 1'b0;
    bus.redirect_pc = '0;
    bus.instr_rdy   = 1'b1;

    // Reset release, 1-cycle memory, streaming at full rate.
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b1;
    @(negedge clk);
    check("rst_vld_c0", bus.instr_vld, 32'd0);
    check("rst_instr_c0", bus.instr, 32'd0);
    check("rst_pc_c0", bus.instr_pc, 32'd0);
    check("rst_req_c0", bus.imReq, 32'd1);
    @(negedge clk);
    check("vld_c1", bus.instr_vld, 32'd0);
    @(negedge clk);
    check("vld_c2", bus.instr_vld, 32'd1);
    check("pc_c2", bus.instr_pc, 32'h0);
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      check("stream_vld", bus.instr_vld, 32'd1);
      check("stream_pc", bus.instr_pc, 32'(i + 1) << 2);
    end

    // Decode stalled: exactly DEPTH requests, then imReq held low.
    bus.instr_rdy = 1'b0;
    do_reset();
    repeat (12) @(negedge clk);
    check("stall_reqs", 32'(req_count), 32'(DEPTH));
    check("stall_req_low", bus.imReq, 32'd0);
    check("stall_vld", bus.instr_vld, 32'd1);
    check("stall_count", dut.count, 32'(DEPTH));
    @(posedge clk);
    #1 bus.instr_rdy = 1'b1;
    @(negedge clk);
    check("drain_first", bus.instr_pc, 32'h0);
    repeat (8) @(negedge clk);

    // 3-cycle memory, redirect with requests in flight.
    lat = 3;
    repeat (12) @(negedge clk);
    check("inflight_ge2", 32'(dut.inflight >= 2), 32'd1);
    do_redirect(32'h0000_0100);
    wait_first("redir_100", 32'h100, 20);
    repeat (10) @(negedge clk);
    check("drop_zero_a", dut.drop, 32'd0);

    // Redirect coinciding with an ack and a pop, then another one.
    lat = 1;
    repeat (10) @(negedge clk);
    @(posedge clk);
    #1 bus.redirect = 1'b1;
    bus.redirect_pc = 32'h0000_0180;
    @(negedge clk);
    check("coincide_ack", bus.imAck, 32'd1);
    check("coincide_pop", 32'(bus.instr_vld & bus.instr_rdy), 32'd1);
    @(posedge clk);
    #1 bus.redirect_pc = 32'h0000_0200;
    @(posedge clk);
    #1 bus.redirect = 1'b0;
    wait_first("redir_200", 32'h200, 20);
    repeat (8) @(negedge clk);
    check("drop_zero_b", dut.drop, 32'd0);
    check("inflight_bound", 32'(dut.inflight <= DEPTH), 32'd1);

    // Misaligned redirect target.
    do_redirect(32'h0000_0103);
    @(negedge clk);
    check("mis_req", bus.imReq, 32'd1);
    check("mis_addr", bus.imAddr, 32'h40);
    wait_first("redir_103", 32'h100, 20);
    repeat (6) @(negedge clk);

    // Asynchronous reset mid-stream with the FIFO partly full.
    @(posedge clk);
    #1 bus.instr_rdy = 1'b0;
    repeat (2) @(negedge clk);
    check("pre_rst_vld", bus.instr_vld, 32'd1);
    @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    check("async_vld", bus.instr_vld, 32'd0);
    check("async_req", bus.imReq, 32'd0);
    bus.instr_rdy = 1'b1;
    @(posedge clk);
    @(posedge clk);
    #2 rst_n = 1'b1;
    @(negedge clk);
    check("resume_addr", bus.imAddr, RESET_PC >> 2);
    wait_first("resume", RESET_PC, 10);
    repeat (6) @(negedge clk);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
